multiplier_32fp: RTL and testbench

MULTIPLIER_32FP -- requirements
Module: multiplier_32fp

---
 rtl/multiplier_32fp_pkg.sv | 32 +++
 rtl/multiplier_32fp_classify.sv | 28 ++
 rtl/multiplier_32fp.sv | 171 +++++++++++++++++
 tb/tb_multiplier_32fp.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_32fp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : multiplier_32fp_pkg
// Brief   : Shared types and constants for the binary32 multiplier.
// Revision: 1.0 - initial release
// ============================================================================
package multiplier_32fp_pkg;

    localparam int          BIAS  = 127;
    localparam int          EXP_W = 8;
    localparam int          MAN_W = 23;
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MULT  = 3'd1,
        S_NORM  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
        logic             is_zero;
        logic             is_inf;
        logic             is_nan;
    } fp_unpacked_t;

endpackage
`default_nettype wire

// File: rtl/multiplier_32fp_classify.sv
`default_nettype none
// ============================================================================
// Module  : fp32_classify
// Brief   : Unpacks a binary32 operand; subnormals classify as zero.
// Revision: 1.0 - initial release
// ============================================================================
module fp32_classify
    import multiplier_32fp_pkg::*;
(
    input  logic [31:0]  i_op,
    output fp_unpacked_t o_unp
);

    logic [EXP_W-1:0] w_exp;
    logic [MAN_W-1:0] w_man;

    assign w_exp = i_op[30:23];
    assign w_man = i_op[22:0];

    assign o_unp.sign    = i_op[31];
    assign o_unp.exp     = w_exp;
    assign o_unp.man     = w_man;
    assign o_unp.is_zero = (w_exp == '0);
    assign o_unp.is_inf  = (&w_exp) && (w_man == '0);
    assign o_unp.is_nan  = (&w_exp) && (w_man != '0);

endmodule
`default_nettype wire

// File: rtl/multiplier_32fp.sv
`default_nettype none
// ============================================================================
// Module  : multiplier_32fp
// Brief   : Multi-cycle IEEE-754 binary32 multiplier, RNE, flush-to-zero.
//           Define MULTIPLIER_32FP_ASSERT_EN to compile protocol assertions.
// Revision: 1.0 - initial release
// ============================================================================
module multiplier_32fp
    import multiplier_32fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        start_i,
    output logic        done_o,
    output logic        nan_o,
    output logic        inifinit_o,
    output logic        overflow_o,
    output logic        underflow_o,
    output logic [31:0] product_o
);

    state_t            r_state, w_state_nxt;
    logic [31:0]       r_a, r_b;
    fp_unpacked_t      w_ua, w_ub;
    logic [47:0]       r_prod;
    logic signed [9:0] r_exp_sum, r_exp_norm, w_exp_fin;
    logic [23:0]       r_mant;
    logic              r_guard, r_round, r_sticky;
    logic              w_capture, w_round_up, w_sign;
    logic [24:0]       w_mant_rnd;
    logic [22:0]       w_man_fin;
    logic [31:0]       w_res;
    logic              w_nan, w_inf, w_ovf, w_unf;

    fp32_classify u_cls_a (.i_op(r_a), .o_unp(w_ua));
    fp32_classify u_cls_b (.i_op(r_b), .o_unp(w_ub));

    assign w_capture = (r_state == S_IDLE) && start_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = S_MULT;
            S_MULT:  w_state_nxt = S_NORM;
            S_NORM:  w_state_nxt = S_ROUND;
            S_ROUND: w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        done_o = (r_state == S_DONE);
    end

    // Rounding stage: RNE increment, then renormalise on mantissa carry-out
    assign w_round_up = r_guard & (r_round | r_sticky | r_mant[0]);
    assign w_mant_rnd = {1'b0, r_mant} + 25'(w_round_up);
    assign w_exp_fin  = w_mant_rnd[24] ? r_exp_norm + 10'sd1 : r_exp_norm;
    assign w_man_fin  = w_mant_rnd[24] ? w_mant_rnd[23:1] : w_mant_rnd[22:0];
    assign w_sign     = w_ua.sign ^ w_ub.sign;

    always_comb begin
        w_res = {w_sign, w_exp_fin[7:0], w_man_fin};
        w_nan = 1'b0;
        w_inf = 1'b0;
        w_ovf = 1'b0;
        w_unf = 1'b0;
        if (w_ua.is_nan || w_ub.is_nan || (w_ua.is_inf && w_ub.is_zero) ||
            (w_ua.is_zero && w_ub.is_inf)) begin
            w_res = QNAN;
            w_nan = 1'b1;
        end else if (w_ua.is_inf || w_ub.is_inf) begin
            w_res = {w_sign, 8'hFF, 23'd0};
            w_inf = 1'b1;
        end else if (w_ua.is_zero || w_ub.is_zero) begin
            w_res = {w_sign, 31'd0};
        end else if (w_exp_fin >= 10'sd255) begin
            w_res = {w_sign, 8'hFF, 23'd0};
            w_inf = 1'b1;
            w_ovf = 1'b1;
        end else if (w_exp_fin <= 10'sd0) begin
            w_res = {w_sign, 31'd0};
            w_unf = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_prod      <= '0;
            r_exp_sum   <= '0;
            r_exp_norm  <= '0;
            r_mant      <= '0;
            r_guard     <= 1'b0;
            r_round     <= 1'b0;
            r_sticky    <= 1'b0;
            product_o   <= '0;
            nan_o       <= 1'b0;
            inifinit_o  <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_capture) begin
                    r_a <= a_i;
                    r_b <= b_i;
                end
                S_MULT: begin
                    r_prod    <= {1'b1, w_ua.man} * {1'b1, w_ub.man};
                    r_exp_sum <= 10'({2'b00, w_ua.exp}) + 10'({2'b00, w_ub.exp}) - 10'(BIAS);
                end
                S_NORM: begin
                    if (r_prod[47]) begin
                        r_mant     <= r_prod[47:24];
                        r_guard    <= r_prod[23];
                        r_round    <= r_prod[22];
                        r_sticky   <= |r_prod[21:0];
                        r_exp_norm <= r_exp_sum + 10'sd1;
                    end else begin
                        r_mant     <= r_prod[46:23];
                        r_guard    <= r_prod[22];
                        r_round    <= r_prod[21];
                        r_sticky   <= |r_prod[20:0];
                        r_exp_norm <= r_exp_sum;
                    end
                end
                S_ROUND: begin
                    product_o   <= w_res;
                    nan_o       <= w_nan;
                    inifinit_o  <= w_inf;
                    overflow_o  <= w_ovf;
                    underflow_o <= w_unf;
                end
                default: ;
            endcase
        end
    end

`ifdef MULTIPLIER_32FP_ASSERT_EN
    logic [3:0] r_cap_hist;
    logic       r_done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_hist <= '0;
            r_done_d   <= 1'b0;
        end else begin
            r_cap_hist <= {r_cap_hist[2:0], w_capture};
            r_done_d   <= done_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(done_o && r_done_d));
            assert ($onehot0({nan_o, overflow_o, underflow_o}));
            assert (done_o == r_cap_hist[3]);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_multiplier_32fp.sv
`default_nettype none
// ============================================================================
// Module  : tb_multiplier_32fp
// Brief   : Self-checking bench: directed vector table, streamed random
//           normals against a double-precision reference, mid-op reset.
// Revision: 1.0 - initial release
// ============================================================================
module tb_multiplier_32fp;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic [3:0]  f;  // {nan, inf, ovf, unf}
    } vec_t;

    typedef struct {
        logic [31:0] p;
        logic [3:0]  f;
    } exp_t;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [31:0] a_i     = '0;
    logic [31:0] b_i     = '0;
    logic        start_i = 1'b0;
    logic        done_o, nan_o, inifinit_o, overflow_o, underflow_o;
    logic [31:0] product_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];
    vec_t tbl[13];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multiplier_32fp dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_i        (a_i),
        .b_i        (b_i),
        .start_i    (start_i),
        .done_o     (done_o),
        .nan_o      (nan_o),
        .inifinit_o (inifinit_o),
        .overflow_o (overflow_o),
        .underflow_o(underflow_o),
        .product_o  (product_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Exact double product of two normal binary32 values, rounded RNE to binary32
    function automatic exp_t ref_mul(input logic [31:0] a, input logic [31:0] b);
        real         ra, rb;
        logic [63:0] d;
        logic [24:0] sum;
        logic [10:0] e;
        logic        up;
        exp_t        r;
        ra  = $bitstoreal({a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0});
        rb  = $bitstoreal({b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0});
        d   = $realtobits(ra * rb);
        up  = d[28] && ((|d[27:0]) || d[29]);
        sum = {2'b01, d[51:29]} + 25'(up);
        e   = d[62:52] - 11'd896 + 11'(sum[24]);
        r.p = {d[63], e[7:0], sum[24] ? 23'd0 : sum[22:0]};
        r.f = 4'b0000;
        return r;
    endfunction

    function automatic logic [31:0] rand_normal();
        return {1'($urandom), 8'($urandom_range(189, 64)), 23'($urandom)};
    endfunction

    task automatic wait_done(output bit found, output int at);
        found = 1'b0;
        at    = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (done_o) begin
                found = 1'b1;
                at    = cyc;
            end
        end
    endtask

    task automatic check_result(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got done pulse, expected none (scoreboard empty)", name);
            return;
        end
        e = sb.pop_front();
        chk({name, " product"}, product_o, e.p);
        chk({name, " flags"}, {28'd0, nan_o, inifinit_o, overflow_o, underflow_o}, {28'd0, e.f});
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input exp_t e);
        bit found;
        int at;
        int cap;
        @(negedge clk);
        a_i     = a;
        b_i     = b;
        start_i = 1'b1;
        sb.push_back(e);
        cap     = cyc + 1;
        @(negedge clk);
        start_i = 1'b0;
        a_i     = $urandom;
        b_i     = $urandom;
        wait_done(found, at);
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s done: got no pulse, expected one", name);
            sb.delete();
            return;
        end
        // done is visible in the cycle following the third edge after capture
        chk({name, " latency"}, 32'(at - cap), 32'd3);
        check_result(name);
        @(negedge clk);
        chk({name, " done width"}, {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        bit   found;
        int   at, prev;
        exp_t e;
        logic [31:0] ra, rb;

        tbl[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000};
        tbl[1]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000};
        tbl[2]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0000};
        tbl[3]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000};
        tbl[4]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0100};
        tbl[5]  = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0110};
        tbl[6]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0001};
        tbl[7]  = '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000};
        tbl[8]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000};
        tbl[9]  = '{32'h00000001, 32'hC0000000, 32'h80000000, 4'b0000};
        tbl[10] = '{32'hFF7FFFFF, 32'h7F7FFFFF, 32'hFF800000, 4'b0110};
        tbl[11] = '{32'h3F800000, 32'hBF800000, 32'hBF800000, 4'b0000};
        tbl[12] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0000};

        repeat (3) @(negedge clk);
        chk("reset product", product_o, 32'd0);
        chk("reset flags", {28'd0, nan_o, inifinit_o, overflow_o, underflow_o}, 32'd0);
        chk("reset done", {31'd0, done_o}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            e.p = tbl[i].p;
            e.f = tbl[i].f;
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, e);
        end

        // start held high, operands refreshed the cycle after each done
        @(negedge clk);
        ra      = rand_normal();
        rb      = rand_normal();
        a_i     = ra;
        b_i     = rb;
        start_i = 1'b1;
        sb.push_back(ref_mul(ra, rb));
        prev    = 0;
        for (int i = 0; i < 100; i++) begin
            wait_done(found, at);
            if (!found) begin
                checks++;
                errors++;
                $display("FAIL stream%0d done: got no pulse, expected one", i);
                sb.delete();
                break;
            end
            check_result($sformatf("stream%0d", i));
            if (i > 0) chk($sformatf("stream%0d spacing", i), 32'(at - prev), 32'd5);
            prev = at;
            @(negedge clk);
            if (i < 99) begin
                ra  = rand_normal();
                rb  = rand_normal();
                a_i = ra;
                b_i = rb;
                sb.push_back(ref_mul(ra, rb));
            end else begin
                start_i = 1'b0;
            end
        end

        // reset asserted while the operation sits in NORM
        repeat (2) @(negedge clk);
        a_i     = 32'h3FC00000;
        b_i     = 32'h40000000;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset product", product_o, 32'd0);
        chk("midreset flags", {28'd0, nan_o, inifinit_o, overflow_o, underflow_o}, 32'd0);
        chk("midreset done", {31'd0, done_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_o) found = 1'b1;
        end
        chk("midreset no done", {31'd0, found}, 32'd0);
        e.p = 32'h40900000;
        e.f = 4'b0000;
        run_op("post-reset", 32'h3FC00000, 32'h40400000, e);

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
